// File: rtl/npu_dma_engine.sv
// PDMA engine: copies LEN words src->dst through a small FIFO,
// pulsing o_dma_finish once the final write has been accepted.
module npu_dma_engine #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int LEN_W      = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ex_dma,
   input  logic [ADDR_W-1:0] i_src_addr,
   input  logic [ADDR_W-1:0] i_dst_addr,
   input  logic [LEN_W-1:0]  i_len,
   output logic              o_busy,
   output logic              o_dma_finish,
   output logic              o_err,
   output logic              o_rd_req,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic              i_rd_gnt,
   input  logic              i_rd_valid,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_wr_req,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   input  logic              i_wr_gnt
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int NW = LEN_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [NW-1:0]     len;
   logic [NW-1:0]     rd_cnt;
   logic [NW-1:0]     wr_cnt;
   logic [CW-1:0]     outst;
   logic [CW-1:0]     fcnt;
   logic [PW-1:0]     wptr;
   logic [PW-1:0]     rptr;
   logic              err;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   logic          rd_hs;
   logic          push;
   logic          pop;
   logic          bad;
   logic [CW:0]   inflight;

   // Reads are throttled so in-flight data always has a FIFO slot.
   assign inflight = {1'b0, fcnt} + {1'b0, outst};
   assign o_rd_req = (state == RUN) && (rd_cnt < len)
                  && (inflight < (CW+1)'(FIFO_DEPTH));
   assign o_rd_addr = src + ADDR_W'(rd_cnt);
   assign o_wr_req  = (state == RUN) && (fcnt != '0);
   assign o_wr_addr = dst + ADDR_W'(wr_cnt);
   assign o_wr_data = o_wr_req ? mem[rptr] : '0;
   assign o_busy       = (state != IDLE);
   assign o_dma_finish = (state == DONE);
   assign o_err        = err;

   assign rd_hs = o_rd_req & i_rd_gnt;
   assign push  = i_rd_valid & (outst != '0);
   assign pop   = o_wr_req & i_wr_gnt;
   assign bad   = (i_rd_valid & (outst == '0))
               | (i_wr_gnt & ~o_wr_req);

   always_ff @(posedge i_clk) begin
      if (push) mem[wptr] <= i_rd_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         src    <= '0;
         dst    <= '0;
         len    <= '0;
         rd_cnt <= '0;
         wr_cnt <= '0;
         outst  <= '0;
         fcnt   <= '0;
         wptr   <= '0;
         rptr   <= '0;
         err    <= 1'b0;
      end else begin
         if (rd_hs) rd_cnt <= rd_cnt + 1'b1;
         outst <= outst + CW'(rd_hs) - CW'(push);
         fcnt  <= fcnt + CW'(push) - CW'(pop);
         if (push) wptr <= wptr + 1'b1;
         if (pop) begin
            rptr   <= rptr + 1'b1;
            wr_cnt <= wr_cnt + 1'b1;
         end
         if (bad) err <= 1'b1;
         case (state)
            IDLE: begin
               if (i_ex_dma) begin
                  src    <= i_src_addr;
                  dst    <= i_dst_addr;
                  len    <= {1'b0, i_len};
                  rd_cnt <= '0;
                  wr_cnt <= '0;
                  outst  <= '0;
                  err    <= 1'b0;
                  state  <= (i_len == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (pop && (wr_cnt + 1'b1 == len)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_npu_dma_engine.sv
// Directed bench for npu_dma_engine with a latency-1 read responder.
module tb_npu_dma_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex = 1'b0;
   logic [15:0] src = '0;
   logic [15:0] dst = '0;
   logic [11:0] len = '0;
   logic        rd_gnt = 1'b0;
   logic        rd_valid = 1'b0;
   logic [31:0] rd_data = '0;
   logic        wr_gnt = 1'b0;
   logic        spur = 1'b0;

   logic        o_busy, o_dma_finish, o_err;
   logic        o_rd_req, o_wr_req;
   logic [15:0] o_rd_addr, o_wr_addr;
   logic [31:0] o_wr_data;

   npu_dma_engine dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ex_dma(ex),
      .i_src_addr(src), .i_dst_addr(dst), .i_len(len),
      .o_busy(o_busy), .o_dma_finish(o_dma_finish), .o_err(o_err),
      .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
      .i_rd_gnt(rd_gnt), .i_rd_valid(rd_valid), .i_rd_data(rd_data),
      .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .i_wr_gnt(wr_gnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int fin_cnt = 0;
   int rd_gnts = 0;
   int req_cnt = 0;
   logic [15:0] ra_q[$];
   logic [15:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic        rg;
   logic [15:0] ra;

   // Monitor plus memory model: read data equals its address.
   always @(posedge clk) begin
      rg = o_rd_req && rd_gnt;
      ra = o_rd_addr;
      if (rg) begin
         ra_q.push_back(ra);
         rd_gnts++;
      end
      if (o_wr_req && wr_gnt) begin
         wa_q.push_back(o_wr_addr);
         wd_q.push_back(o_wr_data);
      end
      if (o_dma_finish) fin_cnt++;
      if (o_rd_req || o_wr_req) req_cnt++;
      #1;
      rd_valid = rg || spur;
      rd_data  = rg ? {16'h0, ra} : 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [15:0] s, input logic [15:0] d,
                        input logic [11:0] l);
      @(negedge clk);
      ex = 1'b1; src = s; dst = d; len = l;
      @(negedge clk);
      ex = 1'b0;
   endtask

   task automatic wait_fin(input string tag, input int budget);
      int n = 0;
      while (!o_dma_finish && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(o_dma_finish), 32'd1);
   endtask

   int b, fb, rb, qb;

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ctl", {27'd0, o_busy, o_dma_finish, o_err, o_rd_req, o_wr_req}, 0);
      chk("rst_addr", {o_rd_addr, o_wr_addr}, 0);
      chk("rst_data", o_wr_data, 0);
      rst_n = 1'b1;

      // 1: always-grant stream
      rd_gnt = 1'b1; wr_gnt = 1'b1;
      b = wa_q.size(); fb = fin_cnt;
      start(16'h0100, 16'h0200, 12'd3);
      wait_fin("t1_fin", 40);
      chk("t1_busy_fin", 32'(o_busy), 1);
      @(negedge clk);
      chk("t1_busy_after", 32'(o_busy), 0);
      repeat (3) @(negedge clk);
      chk("t1_nfin", fin_cnt - fb, 1);
      chk("t1_nwr", wa_q.size() - b, 3);
      for (int i = 0; i < 3; i++) begin
         chk("t1_waddr", 32'(wa_q[b+i]), 32'h0200 + i);
         chk("t1_wdata", wd_q[b+i], 32'h0100 + i);
      end

      // 2: zero length
      qb = req_cnt; fb = fin_cnt;
      start(16'h1234, 16'h4321, 12'd0);
      chk("t2_fin_c1", 32'(o_dma_finish), 1);
      chk("t2_busy_c1", 32'(o_busy), 1);
      @(negedge clk);
      chk("t2_fin_c2", 32'(o_dma_finish), 0);
      chk("t2_busy_c2", 32'(o_busy), 0);
      chk("t2_noreq", req_cnt - qb, 0);
      chk("t2_nfin", fin_cnt - fb, 1);

      // 3: FIFO backpressure
      wr_gnt = 1'b0;
      b = wa_q.size(); fb = fin_cnt; rb = rd_gnts;
      start(16'h0040, 16'h0080, 12'd8);
      repeat (19) @(negedge clk);
      chk("t3_rd_pre", rd_gnts - rb, 4);
      chk("t3_rdreq_lo", 32'(o_rd_req), 0);
      chk("t3_wrreq", 32'(o_wr_req), 1);
      chk("t3_no_wr", wa_q.size() - b, 0);
      wr_gnt = 1'b1;
      wait_fin("t3_fin", 60);
      @(negedge clk);
      chk("t3_nfin", fin_cnt - fb, 1);
      chk("t3_nwr", wa_q.size() - b, 8);
      for (int i = 0; i < 8; i++)
         chk("t3_wdata", wd_q[b+i], 32'h0040 + i);

      // 4: address wrap
      b = wa_q.size(); rb = ra_q.size();
      start(16'hFFFE, 16'hFFFF, 12'd3);
      wait_fin("t4_fin", 40);
      @(negedge clk);
      chk("t4_ra0", 32'(ra_q[rb]), 32'hFFFE);
      chk("t4_ra1", 32'(ra_q[rb+1]), 32'hFFFF);
      chk("t4_ra2", 32'(ra_q[rb+2]), 32'h0000);
      chk("t4_wa0", 32'(wa_q[b]), 32'hFFFF);
      chk("t4_wa1", 32'(wa_q[b+1]), 32'h0000);
      chk("t4_wa2", 32'(wa_q[b+2]), 32'h0001);

      // 5: ignored restart, spurious read data, sticky error
      chk("t5_err_pre", 32'(o_err), 1);
      wr_gnt = 1'b0;
      b = wa_q.size(); fb = fin_cnt;
      start(16'h0500, 16'h0600, 12'd4);
      chk("t5_err_clr", 32'(o_err), 0);
      start(16'h0700, 16'h0800, 12'd1);
      repeat (8) @(negedge clk);
      chk("t5_err_quiet", 32'(o_err), 0);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_err_set", 32'(o_err), 1);
      wr_gnt = 1'b1;
      wait_fin("t5_fin", 40);
      chk("t5_err_hold", 32'(o_err), 1);
      @(negedge clk);
      chk("t5_nwr", wa_q.size() - b, 4);
      chk("t5_wd0", wd_q[b], 32'h0500);
      chk("t5_wa3", 32'(wa_q[b+3]), 32'h0603);
      chk("t5_nfin", fin_cnt - fb, 1);
      wr_gnt = 1'b0;
      start(16'h0000, 16'h0000, 12'd0);
      chk("t5_err_new", 32'(o_err), 0);
      @(negedge clk);

      // 6: reset mid-transfer
      rd_gnt = 1'b1; wr_gnt = 1'b1;
      b = wa_q.size(); fb = fin_cnt;
      start(16'h0300, 16'h0400, 12'd5);
      for (int n = 0; n < 30 && (wa_q.size() - b) < 2; n++)
         @(negedge clk);
      chk("t6_two_wr", wa_q.size() - b, 2);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ctl", {27'd0, o_busy, o_dma_finish, o_err, o_rd_req, o_wr_req}, 0);
      chk("t6_rst_addr", {o_rd_addr, o_wr_addr}, 0);
      chk("t6_rst_data", o_wr_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("t6_nofin", fin_cnt - fb, 0);
      b = wa_q.size(); fb = fin_cnt;
      start(16'h0900, 16'h0A00, 12'd2);
      wait_fin("t6_fin", 40);
      @(negedge clk);
      chk("t6_nwr", wa_q.size() - b, 2);
      chk("t6_wd0", wd_q[b], 32'h0900);
      chk("t6_wd1", wd_q[b+1], 32'h0901);
      chk("t6_wa1", 32'(wa_q[b+1]), 32'h0A01);
      chk("t6_nfin", fin_cnt - fb, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/npu_dma_engine.md
Name: npu_dma_engine

Overview:
- Executes one PDMA instruction per start pulse and reports completion.
- Receives the scheduler's one-cycle o_ex_dma strobe plus the decoded descriptor. Returns the one-cycle dma_finish pulse the scheduler waits on, for both blocking and noblock DMA.
- Moves LEN words from a source address to a destination address through a small internal FIFO.
- Uses a split read-request/read-data port and a write-request port.

Parameters:
- ADDR_W, 16, word address width for source and destination.
- DATA_W, 32, data word width.
- LEN_W, 12, transfer length width in words.
- FIFO_DEPTH, 4, internal buffer entries; must be a power of 2 and at least 2.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ex_dma  in  1  one-cycle start strobe
- i_src_addr  in  ADDR_W  first source word address, sampled at start
- i_dst_addr  in  ADDR_W  first destination word address, sampled at start
- i_len  in  LEN_W  words to move, sampled at start
- o_busy  out  1  transfer in progress
- o_dma_finish  out  1  one-cycle completion pulse
- o_err  out  1  sticky protocol error flag
- o_rd_req  out  1  read request
- o_rd_addr  out  ADDR_W  read address
- i_rd_gnt  in  1  read request accepted this cycle
- i_rd_valid  in  1  read data returned, in order
- i_rd_data  in  DATA_W  read data
- o_wr_req  out  1  write request
- o_wr_addr  out  ADDR_W  write address
- o_wr_data  out  DATA_W  write data
- i_wr_gnt  in  1  write accepted this cycle

Behaviour:
- Reset values: i_rst_n asynchronous, active-low; clock i_clk. On reset, all outputs are 0, the state is IDLE, all counters are 0 and the FIFO is empty.
- States: IDLE, RUN, DONE.
- IDLE:
  - On i_ex_dma, latch src, dst and len.
  - Clear o_err, the read count, the write count and the outstanding count.
  - Go to RUN if len != 0. Go to DONE if len == 0.
- RUN:
  - o_busy = 1.
  - o_rd_req = (reads issued < len) && (fifo_count + outstanding < FIFO_DEPTH). This guarantees returned data never overflows the FIFO.
  - o_rd_addr = src + reads issued, modulo 2^ADDR_W.
  - A request handshake completes when o_rd_req && i_rd_gnt. That cycle, reads issued +1 and outstanding +1.
  - o_rd_req and o_rd_addr hold stable until granted.
  - i_rd_valid pushes i_rd_data into the FIFO and decrements outstanding. Data may return no earlier than the cycle after its grant, with arbitrary latency.
  - o_wr_req = FIFO not empty.
  - o_wr_data = FIFO head.
  - o_wr_addr = dst + writes done, modulo 2^ADDR_W.
  - On i_wr_gnt, pop the FIFO and increment writes done.
  - Push and pop in the same cycle leave the count unchanged.
  - Grant, valid and wr_gnt may all occur in the same cycle; each counter applies its own increment or decrement independently.
  - When writes done reaches len (on the granting cycle), go to DONE.
- DONE:
  - o_dma_finish = 1 for exactly one cycle.
  - o_busy stays 1 in DONE.
  - Next state is IDLE.
  - Latency from i_ex_dma with len == 0: o_dma_finish is high in cycle 1.
- Start handling:
  - i_ex_dma while not IDLE is ignored; no state change and no relatch.
  - i_ex_dma in IDLE has priority in the same cycle that DONE returns to IDLE.
- Protocol errors set o_err = 1, held until the next accepted start:
  - i_rd_valid with outstanding == 0; the data is dropped.
  - i_wr_gnt with o_wr_req == 0; ignored.
- Counters are LEN_W+1 bits wide, so len = 2^LEN_W - 1 completes without overflow.
- Addresses wrap silently at 2^ADDR_W.
- There is no abort input. A stopped scheduler waits for o_dma_finish, so every started transfer runs to completion.
- Reset mid-transfer aborts immediately: the FIFO is emptied and no finish pulse is issued.

Test Plan:
1. Always-grant stream:
   - Stimulus: src=0x0100, dst=0x0200, len=3; i_rd_gnt=1, i_wr_gnt=1 held high; read latency 1; read data = address.
   - Required: writes 0x0200←0x0100, 0x0201←0x0101, 0x0202←0x0102 in order; exactly one o_dma_finish; o_busy falls the cycle after finish.
2. Zero length:
   - Stimulus: len=0.
   - Required: no o_rd_req or o_wr_req; o_dma_finish high in cycle 1; o_busy high in cycle 1 only.
3. FIFO backpressure:
   - Stimulus: len=8, FIFO_DEPTH=4, i_wr_gnt=0 for 20 cycles, then 1.
   - Required: exactly 4 reads granted before the first write; o_rd_req low while fifo+outstanding=4; all 8 words arrive in order; one finish pulse.
4. Address wrap:
   - Stimulus: src=0xFFFE, dst=0xFFFF, len=3.
   - Required: read addresses 0xFFFE, 0xFFFF, 0x0000; write addresses 0xFFFF, 0x0000, 0x0001.
5. Busy and error handling:
   - Stimulus: second i_ex_dma during RUN; spurious i_rd_valid with nothing outstanding.
   - Required: the second start is ignored (original len completes); o_err=1 until the next accepted start clears it.
6. Reset mid-transfer:
   - Stimulus: i_rst_n low after 2 of 5 writes.
   - Required: all outputs 0 during reset, no o_dma_finish; a new len=2 transfer then completes normally.
